stimulus_driver: RTL and testbench
==================================

STIMULUS_DRIVER -- requirements
Module: stimulus_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and event width; only 32 is supported.
REQ-002 SHALL have parameter EVT_LAT, default 2, the cycles from operands presented to the matching checker event valid.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_start, input, 1, run request, sampled only in IDLE.
REQ-006 SHALL have port i_count, input, 16, number of vectors per run, latched on accepted start.
REQ-007 SHALL have port i_seed, input, WIDTH, LFSR seed, latched on accepted start.
REQ-008 SHALL have port o_dut_ia, output, WIDTH, operand A to DUT and checker.
REQ-009 SHALL have port o_dut_ib, output, WIDTH, operand B to DUT and checker.
REQ-010 SHALL have port o_vld, output, 1, high when o_dut_ia/o_dut_ib carry a run vector.
REQ-011 SHALL have port i_event, input, WIDTH, checker result; bit 0 = 1 means pass, other bits ignored.
REQ-012 SHALL have ports o_busy (1), o_done (1), o_pass_cnt (16) and o_fail_cnt (16), all outputs: run status and tallies.

Function
REQ-013 SHALL implement states IDLE, CORNER, RANDOM, DRAIN, DONE.
REQ-014 SHALL, in IDLE with i_start=1, latch i_count and i_seed, clear both tallies, and go to CORNER; with latched count 0 it SHALL go to DRAIN instead.
REQ-015 SHALL, in CORNER, drive one vector per cycle in order: (0,0), (FFFFFFFF,1), (7FFFFFFF,1), (FFFFFFFF,FFFFFFFF), then go to RANDOM.
REQ-016 SHALL, in RANDOM, drive A from LFSR-A and B from LFSR-B, advancing both once per vector.
REQ-017 SHALL use 32-bit Galois LFSRs with mask 80200003: LFSR-A seeded i_seed, LFSR-B seeded ~i_seed; a zero seed value SHALL be replaced by 00000001.
REQ-018 SHALL stop after exactly i_count vectors in total, counting corner vectors; if i_count<4, corner vectors SHALL be truncated. It SHALL then enter DRAIN.
REQ-019 SHALL hold o_vld=1 only during vector cycles; o_dut_ia and o_dut_ib SHALL be 0 whenever o_vld=0.
REQ-020 SHALL remain in DRAIN for EVT_LAT cycles, enter DONE for one cycle with o_done=1, then return to IDLE.
REQ-021 SHALL delay o_vld through an EVT_LAT-deep shift register, and count i_event[0] only when the delayed bit is 1: increment o_pass_cnt if 1, else o_fail_cnt.
REQ-022 SHALL drive o_busy=1 in CORNER, RANDOM and DRAIN.
REQ-023 SHALL ignore i_start outside IDLE.
REQ-024 SHALL hold tallies after DONE until the next accepted start.
REQ-025 SHALL let tallies wrap modulo 2^16; they cannot exceed i_count.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, enter IDLE and zero o_dut_ia, o_dut_ib, o_vld, o_busy, o_done, both tallies, both LFSRs, the latched count and the delay line.
REQ-027 SHALL abandon a run on reset mid-run with no o_done pulse; reset overrides i_start in the same cycle.

Structure
REQ-028 SHALL take the state encoding, LFSR mask 80200003 and the four corner operand pairs from shared package stim_pkg.
REQ-029 SHALL instantiate sub-module lfsr32 (load, seed, advance, value) twice.

Verification
REQ-030 SHALL cover: i_count=4, correct adder -> corner pairs in order, o_vld high 4 cycles, o_done in cycle 7 after start edge, pass=4, fail=0.
REQ-031 SHALL cover: i_count=10, seed 0 -> LFSR-A seeded 00000001, LFSR-B seeded FFFFFFFF, 10 vectors, pass=10.
REQ-032 SHALL cover: i_count=6, DUT forced to return sum+1 -> pass=0, fail=6.
REQ-033 SHALL cover: i_count=0 -> o_vld never high, o_done after EVT_LAT+1 cycles, tallies 0.
REQ-034 SHALL cover: reset asserted during RANDOM -> next cycle IDLE, all outputs 0, no o_done.
REQ-035 SHALL cover: i_start pulsed while busy -> ignored; run completes with original i_count.

Source files
------------

// File: rtl/stim_pkg.sv
// stim_pkg: shared definitions for the stimulus driver.
//   state_t         - run-sequencer state encoding
//   LFSR_MASK       - Galois feedback mask for the 32-bit operand LFSRs
//   CORNER_A/B      - the four fixed corner operand pairs, issued in order
//   lfsr_step()     - one right-shifting Galois LFSR step
package stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORNER,
    S_RANDOM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam logic [31:0] CORNER_A [4] = '{32'h0000_0000, 32'hFFFF_FFFF,
                                           32'h7FFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] CORNER_B [4] = '{32'h0000_0000, 32'h0000_0001,
                                           32'h0000_0001, 32'hFFFF_FFFF};

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// lfsr32: 32-bit Galois LFSR with load and advance.
//   clk, reset  - clock, synchronous active-high reset (clears value)
//   i_load      - load i_seed (a zero seed is replaced by 1); wins over advance
//   i_seed      - seed value
//   i_advance   - step the LFSR once
//   o_value     - current LFSR value
module lfsr32
  import stim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_advance,
  output logic [31:0] o_value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_value <= '0;
    end else if (i_load) begin
      // all-zero is the lock-up state of the LFSR
      o_value <= (i_seed == '0) ? 32'h0000_0001 : i_seed;
    end else if (i_advance) begin
      o_value <= lfsr_step(o_value);
    end
  end

endmodule

// File: rtl/stimulus_driver.sv
// stimulus_driver: issues a run of i_count operand pairs to a DUT/checker
// pair (four corner vectors first, then LFSR vectors), tallies the checker's
// pass/fail events, then drains and pulses o_done.
//   clk, reset              - clock, synchronous active-high reset
//   i_start                 - run request, honoured only in IDLE
//   i_count, i_seed         - vectors per run and LFSR seed, latched on start
//   o_dut_ia, o_dut_ib      - operands (zero when o_vld is low)
//   o_vld                   - operands carry a run vector
//   i_event                 - checker result, bit 0 = pass
//   o_busy, o_done          - run status (registered from state)
//   o_pass_cnt, o_fail_cnt  - event tallies, held until the next start
module stimulus_driver
  import stim_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int EVT_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [15:0]      i_count,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_dut_ia,
  output logic [WIDTH-1:0] o_dut_ib,
  output logic             o_vld,
  input  logic [WIDTH-1:0] i_event,
  output logic             o_busy,
  output logic             o_done,
  output logic [15:0]      o_pass_cnt,
  output logic [15:0]      o_fail_cnt
);

  state_t             r_state;
  logic [15:0]        r_count;
  logic [15:0]        r_idx;
  logic [7:0]         r_drain;
  logic [EVT_LAT-1:0] r_vld_dly;

  logic        w_load;
  logic        w_advance;
  logic        w_last;
  logic        w_evt_vld;
  logic [31:0] w_lfsr_a;
  logic [31:0] w_lfsr_b;
  logic        w_unused_evt;

  assign w_load       = (r_state == S_IDLE) && i_start;
  assign w_advance    = (r_state == S_RANDOM);
  assign w_last       = ((r_idx + 16'd1) == r_count);
  assign w_evt_vld    = r_vld_dly[EVT_LAT-1];
  assign w_unused_evt = ^i_event[WIDTH-1:1];

  lfsr32 u_lfsr_a (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_seed    (i_seed),
    .i_advance (w_advance),
    .o_value   (w_lfsr_a)
  );

  lfsr32 u_lfsr_b (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_seed    (~i_seed),
    .i_advance (w_advance),
    .o_value   (w_lfsr_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_idx      <= '0;
      r_drain    <= '0;
      r_vld_dly  <= '0;
      o_dut_ia   <= '0;
      o_dut_ib   <= '0;
      o_vld      <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass_cnt <= '0;
      o_fail_cnt <= '0;
    end else begin
      o_dut_ia <= '0;
      o_dut_ib <= '0;
      o_vld    <= 1'b0;
      o_done   <= (r_state == S_DONE);
      o_busy   <= (r_state == S_CORNER) || (r_state == S_RANDOM) ||
                  (r_state == S_DRAIN);

      // o_vld delayed to line up with the checker's event for that vector
      r_vld_dly[0] <= o_vld;
      for (int unsigned i = 1; i < EVT_LAT; i++) begin
        r_vld_dly[i] <= r_vld_dly[i-1];
      end

      if (w_evt_vld) begin
        if (i_event[0]) o_pass_cnt <= o_pass_cnt + 16'd1;
        else            o_fail_cnt <= o_fail_cnt + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_count    <= i_count;
            r_idx      <= '0;
            r_drain    <= '0;
            o_pass_cnt <= '0;
            o_fail_cnt <= '0;
            r_state    <= (i_count == '0) ? S_DRAIN : S_CORNER;
          end
        end
        S_CORNER: begin
          o_vld    <= 1'b1;
          o_dut_ia <= CORNER_A[r_idx[1:0]];
          o_dut_ib <= CORNER_B[r_idx[1:0]];
          r_idx    <= r_idx + 16'd1;
          // a short run ends inside the corner set
          if (w_last)             r_state <= S_DRAIN;
          else if (r_idx == 16'd3) r_state <= S_RANDOM;
        end
        S_RANDOM: begin
          o_vld    <= 1'b1;
          o_dut_ia <= w_lfsr_a;
          o_dut_ib <= w_lfsr_b;
          r_idx    <= r_idx + 16'd1;
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_drain == 8'(EVT_LAT - 1)) r_state <= S_DONE;
          else                            r_drain <= r_drain + 8'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stimulus_driver.sv
module tb_stimulus_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_count = '0;
  logic [31:0] i_seed = '0;
  logic [31:0] o_dut_ia, o_dut_ib;
  logic        o_vld, o_busy, o_done;
  logic [31:0] i_event;
  logic [15:0] o_pass_cnt, o_fail_cnt;

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] q[$];
  logic        fault = 1'b0;
  logic        ev0 = 1'b0, ev1 = 1'b0;
  logic [30:0] junk = '0;

  logic [31:0] ca [4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] cb [4] = '{32'h0, 32'h1, 32'h1, 32'hFFFF_FFFF};

  always #5 clk = ~clk;

  stimulus_driver #(.WIDTH(32), .EVT_LAT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .i_count    (i_count),
    .i_seed     (i_seed),
    .o_dut_ia   (o_dut_ia),
    .o_dut_ib   (o_dut_ib),
    .o_vld      (o_vld),
    .i_event    (i_event),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pass_cnt (o_pass_cnt),
    .o_fail_cnt (o_fail_cnt)
  );

  // DUT adder (optionally off by one) plus checker, two cycles of latency
  always @(posedge clk) begin
    ev0  <= ((o_dut_ia + o_dut_ib + {31'b0, fault}) == (o_dut_ia + o_dut_ib));
    ev1  <= ev0;
    junk <= 31'($urandom);
  end
  assign i_event = {junk, ev1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic push_expected(input logic [15:0] cnt, input logic [31:0] seed);
    logic [31:0] a, b;
    a = (seed == 0) ? 32'h1 : seed;
    b = (~seed == 0) ? 32'h1 : ~seed;
    for (int i = 0; i < int'(cnt); i++) begin
      if (i < 4) q.push_back({ca[i], cb[i]});
      else begin
        q.push_back({a, b});
        a = m_step(a);
        b = m_step(b);
      end
    end
  endtask

  // scoreboard: every vector cycle must match the next expected pair
  always @(negedge clk) begin
    logic [63:0] e;
    if (o_vld) begin
      if (q.size() == 0) check("vec_unexpected", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        check("vec_a", o_dut_ia, e[63:32]);
        check("vec_b", o_dut_ib, e[31:0]);
      end
    end else begin
      check("idle_a_zero", o_dut_ia, 32'h0);
      check("idle_b_zero", o_dut_ib, 32'h0);
    end
  end

  task automatic run(input logic [15:0] cnt, input logic [31:0] seed, input logic flt,
                     input int poke_cyc, input int rst_cyc);
    int cyc, done_cyc, vld_n, done_n;
    push_expected(cnt, seed);
    fault = flt;
    @(negedge clk);
    i_count = cnt; i_seed = seed; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_count = 16'hFFFF; i_seed = 32'h0;
    cyc = 0; done_cyc = -1; vld_n = 0;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (o_vld) vld_n++;
      if (o_done) done_cyc = cyc;
      i_start = (cyc == poke_cyc);
      if (cyc == poke_cyc) i_count = cnt + 16'd3;
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_ia", o_dut_ia, 32'h0);
        check("rst_ib", o_dut_ib, 32'h0);
        check("rst_flags", {28'b0, o_vld, o_busy, o_done, 1'b0}, 32'h0);
        check("rst_pass", {16'b0, o_pass_cnt}, 32'h0);
        check("rst_fail", {16'b0, o_fail_cnt}, 32'h0);
        q.delete();
        done_n = 0;
        repeat (12) begin
          @(negedge clk);
          if (o_done) done_n++;
        end
        check("rst_no_done", 32'(done_n), 32'd0);
        check("rst_stays_idle", {31'b0, o_busy}, 32'h0);
        return;
      end
    end
    i_start = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(int'(cnt) + 3));
    check("vld_cycles", 32'(vld_n), {16'b0, cnt});
    check("pass_cnt", {16'b0, o_pass_cnt}, flt ? 32'h0 : {16'b0, cnt});
    check("fail_cnt", {16'b0, o_fail_cnt}, flt ? {16'b0, cnt} : 32'h0);
    check("queue_empty", 32'(q.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", {30'b0, o_done, o_busy}, 32'h0);
    repeat (3) @(negedge clk);
    check("pass_held", {16'b0, o_pass_cnt}, flt ? 32'h0 : {16'b0, cnt});
    check("fail_held", {16'b0, o_fail_cnt}, flt ? {16'b0, cnt} : 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_flags", {29'b0, o_vld, o_busy, o_done}, 32'h0);
    check("reset_pass", {16'b0, o_pass_cnt}, 32'h0);
    check("reset_fail", {16'b0, o_fail_cnt}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run(16'd4,  32'h1234_5678, 1'b0, -1, -1);  // corners only
    run(16'd10, 32'h0000_0000, 1'b0, -1, -1);  // zero seed substitution
    run(16'd6,  32'hDEAD_BEEF, 1'b1, -1, -1);  // faulty adder
    run(16'd0,  32'h1111_1111, 1'b0, -1, -1);  // empty run
    run(16'd20, 32'hCAFE_F00D, 1'b0, -1,  7);  // reset during RANDOM
    run(16'd6,  32'hA5A5_A5A5, 1'b0,  2, -1);  // start while busy
    run(16'd2,  32'h0BAD_CAFE, 1'b0, -1, -1);  // truncated corners
    run(16'd9,  32'hFFFF_FFFF, 1'b0, -1, -1);  // inverted seed is zero

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
